// File: rtl/regfile_param.sv
// Parametrised CPU register file: NRD combinational read ports, two write ports, busy scoreboard,
// post-reset clear sequencer. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NRD*ADDR_W-1:0]    rs,
  output logic [NRD*DATA_W-1:0]    rdata,
  output logic [NRD-1:0]           rbusy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        ws0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        ws1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // Handshake: none. Writes, allocs and reads are single-cycle strobes that only take
  // effect while ready=1; there is no back-pressure, so callers must wait for ready.

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic                    clr_we;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]        busy_q;
  logic                    w0_ok, w1_ok, alloc_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_PTR) state_d = S_RUN;
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign ready     = (state_q == S_RUN);
  assign dbg_state = state_q;

  // Reset dominates any write presented on the same edge.
  assign w0_ok    = ready && !rst && we0 && (ws0 != '0);
  assign w1_ok    = ready && !rst && we1 && (ws1 != '0);
  assign alloc_ok = ready && !rst && alloc_en && (alloc_addr != '0);

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) mem[ptr_q] <= '0;
    if (w0_ok)          mem[ws0]   <= wd0;
    if (w1_ok)          mem[ws1]   <= wd1;
  end

  // Alloc is applied after the write clears so a new producer keeps the entry busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (w0_ok)    busy_q[ws0]        <= 1'b0;
      if (w1_ok)    busy_q[ws1]        <= 1'b0;
      if (alloc_ok) busy_q[alloc_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_val;
    logic              rb_val;

    assign ra = rs[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd_val = '0;
      rb_val = 1'b0;
      if (ready && (ra != '0)) begin
        rd_val = mem[ra];
        rb_val = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        if (we1 && (ws1 == ra))      rd_val = wd1;
        else if (we0 && (ws0 == ra)) rd_val = wd0;
        if (((we1 && (ws1 == ra)) || (we0 && (ws0 == ra))) &&
            !(alloc_en && (alloc_addr == ra)))
          rb_val = 1'b0;
`endif
      end
    end

    assign rdata[k*DATA_W +: DATA_W] = rd_val;
    assign rbusy[k]                  = rb_val;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: randomized traffic against an array/counter model,
// plus literal expectations for the clear timing, collisions, scoreboard and bypass.
module tb_regfile_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  ready;
  logic [NRD*ADDR_W-1:0] rs;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  we0, we1, alloc_en;
  logic [ADDR_W-1:0]     ws0, ws1, alloc_addr;
  logic [DATA_W-1:0]     wd0, wd1;
  logic                  dbg_state;

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .ready(ready), .rs(rs), .rdata(rdata), .rbusy(rbusy),
    .we0(we0), .ws0(ws0), .wd0(wd0), .we1(we1), .ws1(ws1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .dbg_state(dbg_state)
  );

  // behavioural model
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_busy [DEPTH];
  bit                m_ready = 1'b0;
  bit                started = 1'b0;
  int                rel_cycles = 0;

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rd(input int k);
    return rdata[k*DATA_W +: DATA_W];
  endfunction

  task automatic set_rs(input int k, input int a);
    rs[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
  endtask

  task automatic rand_inputs();
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    alloc_en = 1'($urandom_range(0, 1));
    ws0 = ADDR_W'($urandom_range(0, 7));
    ws1 = ADDR_W'($urandom_range(0, 7));
    alloc_addr = ADDR_W'($urandom_range(0, 7));
    wd0 = $urandom;
    wd1 = $urandom;
    for (int k = 0; k < NRD; k++)
      set_rs(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7));
  endtask

  task automatic compare();
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    bit eb;
    bit hit0, hit1;
    check("ready", 64'(ready), 64'(m_ready));
    check("dbg_state", 64'(dbg_state), 64'(m_ready));
    for (int k = 0; k < NRD; k++) begin
      ea = rs[k*ADDR_W +: ADDR_W];
      ed = '0;
      eb = 1'b0;
      if (m_ready && ea != 0) begin
        ed = m_mem[ea];
        eb = m_busy[ea];
`ifdef REGFILE_BYPASS_EN
        hit1 = we1 && ws1 == ea;
        hit0 = we0 && ws0 == ea;
        if (hit1) ed = wd1;
        else if (hit0) ed = wd0;
        if ((hit0 || hit1) && !(alloc_en && alloc_addr == ea)) eb = 1'b0;
`else
        hit0 = 1'b0;
        hit1 = 1'b0;
`endif
      end
      exp_q.push_back(ed);
      check($sformatf("rbusy[%0d]", k), 64'(rbusy[k]), 64'(eb));
    end
    for (int k = 0; k < NRD; k++) begin
      ed = exp_q.pop_front();
      check($sformatf("rdata[%0d]", k), 64'(rd(k)), 64'(ed));
    end
  endtask

  task automatic model_update();
    if (rst) begin
      started = 1'b1;
      m_ready = 1'b0;
      rel_cycles = 0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else if (started) begin
      if (m_ready) begin
        if (we0 && ws0 != 0) begin m_mem[ws0] = wd0; m_busy[ws0] = 1'b0; end
        if (we1 && ws1 != 0) begin m_mem[ws1] = wd1; m_busy[ws1] = 1'b0; end
        if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      end else begin
        rel_cycles++;
        if (rel_cycles == DEPTH - 1) begin
          m_ready = 1'b1;
          foreach (m_mem[i]) m_mem[i] = '0;
        end
      end
    end
  endtask

  // driver: inputs are stable from posedge+1; compare at negedge, model steps at posedge
  task automatic cycle();
    @(negedge clk);
    if (started) compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      we0 = 1'b1; ws0 = ADDR_W'(12); wd0 = 32'hCAFEF00D;
      cycle();
      n++;
      if (ready === 1'b1) break;
    end
  endtask

  initial begin
    int n;
    foreach (m_mem[i]) m_mem[i] = '0;
    rst = 1'b1;
    rs = '0; ws0 = '0; ws1 = '0; alloc_addr = '0; wd0 = '0; wd1 = '0;
    idle();
    repeat (3) cycle();
    check("ready_in_reset", 64'(ready), 64'(0));

    rst = 1'b0;
    wait_ready(n);
    check("clear_cycles", 64'(n), 64'(31));
    idle();
    set_rs(0, 12); set_rs(1, 31);
    #1;
    check("clear_write_ignored", 64'(rd(0)), 64'(0));
    check("entry31_zero", 64'(rd(1)), 64'(0));

    // basic write / read back
    we0 = 1'b1; ws0 = 5; wd0 = 32'hDEADBEEF;
    cycle();
    idle(); set_rs(0, 5); #1;
    check("write5", 64'(rd(0)), 64'hDEADBEEF);
    we0 = 1'b1; ws0 = 0; wd0 = 32'h12345678;
    cycle();
    idle(); set_rs(0, 0); #1;
    check("write0_discarded", 64'(rd(0)), 64'(0));

    // collision: port 1 wins
    we0 = 1'b1; ws0 = 7; wd0 = 32'h11111111;
    we1 = 1'b1; ws1 = 7; wd1 = 32'h22222222;
    cycle();
    idle(); set_rs(1, 7); #1;
    check("collision7", 64'(rd(1)), 64'h22222222);

    // scoreboard
    alloc_en = 1'b1; alloc_addr = 9;
    cycle();
    idle(); set_rs(0, 9); #1;
    check("busy9_set", 64'(rbusy[0]), 64'(1));
    we1 = 1'b1; ws1 = 9; wd1 = 32'h00000099;
    cycle();
    idle(); #1;
    check("busy9_clr", 64'(rbusy[0]), 64'(0));
    alloc_en = 1'b1; alloc_addr = 9; we1 = 1'b1; ws1 = 9; wd1 = 32'h0000009A;
    cycle();
    idle(); #1;
    check("busy9_alloc_wins", 64'(rbusy[0]), 64'(1));

    // bypass / no bypass
    we1 = 1'b1; ws1 = 3; wd1 = 32'h00001234;
    cycle();
    idle(); set_rs(1, 3);
    we0 = 1'b1; ws0 = 3; wd0 = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", 64'(rd(1)), 64'hA5A5A5A5);
`else
    check("bypass_same", 64'(rd(1)), 64'h00001234);
`endif
    cycle();
    idle(); #1;
    check("bypass_next", 64'(rd(1)), 64'hA5A5A5A5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // reset from RUN, then reset again mid-clear
    idle(); rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      cycle();
    end
    check("ready_midclear", 64'(ready), 64'(0));
    idle(); rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_ready(n);
    check("reclear_cycles", 64'(n), 64'(31));
    idle(); set_rs(0, 5); set_rs(1, 9); #1;
    check("reclear_entry5", 64'(rd(0)), 64'(0));
    check("reclear_busy9", 64'(rbusy[1]), 64'(0));

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
